// File: rtl/seq_det_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_sched_pkg
// Shared types and helpers for the sequence-detector scheduler.
//   state_t   : scheduler FSM encoding (IDLE, SHIFT, DRAIN, RESP)
//   id_width  : width of a requester index (never below 1 bit)
//   sat_inc   : increment that stops at 2^w-1 (w up to 16)
// ---------------------------------------------------------------------------
package seq_det_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Saturating increment of a w-bit value carried in a 16-bit container.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input int w);
    logic [16:0] maxv;
    maxv = (17'd1 << w) - 17'd1;
    if ({1'b0, v} >= maxv) return v;
    else                   return v + 16'd1;
  endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requester at or after
// last_grant+1 (mod N) whose request bit is set.
// Ports:
//   i_req        [N-1:0]   request vector
//   i_last_grant [IDW-1:0] index granted most recently
//   o_grant      [N-1:0]   one-hot grant (zero when no request)
//   o_grant_idx  [IDW-1:0] index of the granted requester
//   o_any                  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last_grant,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_idx,
  output logic           o_any
);

  int w_idx;

  // Walk offsets 1..N from the last grant; the first hit wins, later hits
  // are masked by o_any.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_last_grant) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// ---------------------------------------------------------------------------
// seq_det_scheduler
// Shares one serial Moore sequence detector among NUM_REQ requesters. A job
// word is shifted MSB-first into the detector and the cycles with
// det_out=1 are counted (saturating at 2^CNT_W-1, CNT_W <= 16).
// Ports:
//   clock, reset (async, active high)
//   req_valid/req_data/req_ready : per-requester job interface
//   det_reset, det_sequence_in   : flop-driven detector controls
//   det_out                      : detector output (registered Moore)
//   rsp_valid/rsp_id/rsp_count/rsp_ready : response interface
//   busy                         : FSM not in IDLE
//   dbg_state                    : current FSM state
// Optional build macro SEQ_DET_SCHED_STATS_EN adds stat_jobs[15:0] and
// stat_hits[15:0] (wrapping job and unsaturated hit totals).
//
// Handshakes: a requester holds req_valid and req_data stable until it sees
// req_ready (a one-cycle, one-hot pulse issued only in IDLE); dropping
// req_valid earlier withdraws the request. A response transfers on a
// rising edge where rsp_valid && rsp_ready; rsp_id/rsp_count are stable
// while rsp_valid is waiting.
// ---------------------------------------------------------------------------
module seq_det_scheduler
  import seq_det_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WORD_W  = 8,
  parameter  int CNT_W   = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      det_reset,
  output logic                      det_sequence_in,
  input  logic                      det_out,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  input  logic                      rsp_ready,
  output logic                      busy,
  output state_t                    dbg_state
`ifdef SEQ_DET_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_jobs,
  output logic [15:0]               stat_hits
`endif
);

  localparam int BIT_W = $clog2(WORD_W + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WORD_W-1:0]   r_shift;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last_grant;
  logic                r_det_reset;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any;
  logic [WORD_W-1:0]   w_word;
  logic                w_last_bit;
  logic                w_sample;
  logic                w_rsp_fire;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  assign w_word     = req_data[int'(w_grant_idx)*WORD_W +: WORD_W];
  assign w_last_bit = (r_bit_cnt == BIT_W'(WORD_W - 1));
  // The detector answers one cycle after each bit, so the first SHIFT cycle
  // carries no useful det_out and DRAIN carries the answer to the last bit.
  assign w_sample   = ((r_state == SHIFT) && (r_bit_cnt != '0)) ||
                      (r_state == DRAIN);
  assign w_rsp_fire = (r_state == RESP) && rsp_ready;

  // ---------------- FSM: state register ----------------
  // det_reset follows the next state so it changes together with the state
  // and leaves a flop without any gating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_det_reset <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_det_reset <= (w_next_state == IDLE) || (w_next_state == RESP);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any)      w_next_state = SHIFT;
      SHIFT:   if (w_last_bit) w_next_state = DRAIN;
      DRAIN:                   w_next_state = RESP;
      RESP:    if (rsp_ready)  w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = '0;
    if ((r_state == IDLE) && !reset) req_ready = w_grant;
    busy      = (r_state != IDLE);
    rsp_valid = (r_state == RESP);
  end

  // ---------------- datapath ----------------
  // The shift register fills with zeros as it empties, so its MSB (which
  // drives det_sequence_in directly) is 0 outside SHIFT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cnt        <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_shift   <= w_word;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_id      <= w_grant_idx;
          end
        end
        SHIFT: begin
          r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        default: ;
      endcase
      if (w_sample && det_out) r_cnt <= CNT_W'(sat_inc(16'(r_cnt), CNT_W));
      if (w_rsp_fire)          r_last_grant <= r_id;
    end
  end

  assign det_reset       = r_det_reset;
  assign det_sequence_in = r_shift[WORD_W-1];
  assign rsp_id          = r_id;
  assign rsp_count       = r_cnt;
  assign dbg_state       = r_state;

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [BIT_W-1:0] r_hits;
  logic [15:0]      r_stat_jobs;
  logic [15:0]      r_stat_hits;

  // Unsaturated per-job hit count feeding the running total.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hits      <= '0;
      r_stat_jobs <= '0;
      r_stat_hits <= '0;
    end else begin
      if ((r_state == IDLE) && w_any) r_hits <= '0;
      else if (w_sample && det_out)   r_hits <= r_hits + 1'b1;
      if (w_rsp_fire) begin
        r_stat_jobs <= r_stat_jobs + 16'd1;
        r_stat_hits <= r_stat_hits + 16'(r_hits);
      end
    end
  end

  assign stat_jobs = r_stat_jobs;
  assign stat_hits = r_stat_hits;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_det_scheduler
// Directed bench for seq_det_scheduler. Main instance uses an echo stub
// detector (det_out = det_sequence_in delayed one cycle); a second instance
// with CNT_W=2 sees det_out held high. Expected grants and responses are
// queued by the stimulus and consumed by independent monitors.
// ---------------------------------------------------------------------------
module tb_seq_det_scheduler;
  import seq_det_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;
  localparam int RSP_W   = ID_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*WORD_W-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      det_reset, det_seq, det_out, echo;
  logic                      rsp_valid, rsp_ready = 1'b1, busy;
  logic [ID_W-1:0]           rsp_id;
  logic [CNT_W-1:0]          rsp_count;
  state_t                    dbg_state;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [15:0]               stat_jobs, stat_hits;
`endif

  always @(posedge clk) echo <= det_seq;
  assign det_out = echo;

  seq_det_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .det_reset(det_reset), .det_sequence_in(det_seq), .det_out(det_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .rsp_ready(rsp_ready), .busy(busy), .dbg_state(dbg_state)
`ifdef SEQ_DET_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_hits(stat_hits)
`endif
  );

  // ---------------- saturation DUT (CNT_W=2, det_out stuck at 1) ----------
  logic [NUM_REQ-1:0]        s_req_valid = '0;
  logic [NUM_REQ*WORD_W-1:0] s_req_data  = '0;
  logic [NUM_REQ-1:0]        s_req_ready;
  logic                      s_det_reset, s_det_seq, s_rsp_valid, s_busy;
  logic [ID_W-1:0]           s_rsp_id;
  logic [1:0]                s_rsp_count;
  state_t                    s_dbg_state;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [15:0]               s_stat_jobs, s_stat_hits;
`endif

  seq_det_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(2)) dut_sat (
    .clock(clk), .reset(rst),
    .req_valid(s_req_valid), .req_data(s_req_data), .req_ready(s_req_ready),
    .det_reset(s_det_reset), .det_sequence_in(s_det_seq), .det_out(1'b1),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_count(s_rsp_count),
    .rsp_ready(1'b1), .busy(s_busy), .dbg_state(s_dbg_state)
`ifdef SEQ_DET_SCHED_STATS_EN
    , .stat_jobs(s_stat_jobs), .stat_hits(s_stat_hits)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [RSP_W-1:0] exp_q[$];
  logic [ID_W-1:0]  grant_q[$];
  logic [RSP_W-1:0] exp_rsp;
  logic [ID_W-1:0]  exp_gnt;
  logic [NUM_REQ-1:0] exp_onehot;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_job(input int id, input int cnt);
    logic [ID_W-1:0]  i;
    logic [CNT_W-1:0] c;
    i = ID_W'(id);
    c = CNT_W'(cnt);
    exp_q.push_back({i, c});
  endtask

  // Response monitor: compares every transferred response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_unexpected: got id %0d count %0d, expected no response", rsp_id, rsp_count);
      end else begin
        exp_rsp = exp_q.pop_front();
        check("rsp_id_count", 32'({rsp_id, rsp_count}), 32'(exp_rsp));
      end
    end
  end

  // Grant monitor: every req_ready pulse must match the next expected grant.
  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (grant_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL grant_unexpected: got req_ready %b, expected none", req_ready);
      end else begin
        exp_gnt    = grant_q.pop_front();
        exp_onehot = '0;
        exp_onehot[exp_gnt] = 1'b1;
        check("grant", 32'(req_ready), 32'(exp_onehot));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_word(input int id, input logic [WORD_W-1:0] w);
    req_data[id*WORD_W +: WORD_W] = w;
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no req_ready in 40 cycles, expected a grant", name);
    end
  endtask

  task automatic wait_rsp(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no rsp_valid in 40 cycles, expected a response", name);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_det_reset"}, 32'(det_reset), 32'd1);
    check({name, "_det_seq"},   32'(det_seq),   32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({name, "_rsp_count"}, 32'(rsp_count), 32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
    check({name, "_state"},     32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [WORD_W-1:0] word;
  int stamps[5];

  initial begin
    // Reset state
    repeat (3) tick();
    req_valid = 4'hF;                  // requests during reset must not be granted
    #1;
    check_reset_values("reset");
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("post_reset");

    // Round robin: all four requesting continuously, rsp_ready high
    set_word(0, 8'h00); set_word(1, 8'hFF); set_word(2, 8'h81); set_word(3, 8'h3C);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    push_job(0, 0); push_job(1, 8); push_job(2, 2); push_job(3, 4); push_job(0, 0);
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr");
      stamps[g] = cyc;
      tick();
    end
    req_valid = '0;
    for (int g = 1; g < 5; g++) check("rr_period", 32'(stamps[g] - stamps[g-1]), 32'd11);
    drain("rr");

    // Single job: requester 2 sends 8'hB5
    tick();
    word = 8'hB5;
    set_word(2, word);
    grant_q.push_back(2);
    push_job(2, 5);
    req_valid = 4'b0100;
    wait_grant("single");
    tick();                             // cycle 1
    req_valid = '0;
    for (int c = 1; c <= WORD_W; c++) begin
      @(negedge clk);
      check($sformatf("single_bit%0d", c), 32'(det_seq), 32'(word[WORD_W-c]));
      if (c == 1) check("single_det_reset_low", 32'(det_reset), 32'd0);
    end
    @(negedge clk);                     // cycle 9 (DRAIN)
    check("single_rsp_valid_c9", 32'(rsp_valid), 32'd0);
    @(negedge clk);                     // cycle 10
    check("single_rsp_valid_c10", 32'(rsp_valid), 32'd1);
    drain("single");

    // Backpressure on requester 1 while requester 3 waits
    tick();
    rsp_ready = 1'b0;
    set_word(1, 8'h0F);
    set_word(3, 8'hA0);
    grant_q.push_back(1); push_job(1, 4);
    grant_q.push_back(3); push_job(3, 2);
    req_valid = 4'b0010;
    wait_grant("bp");
    tick();
    req_valid = 4'b1000;
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id",    32'(rsp_id),    32'd1);
      check("bp_rsp_count", 32'(rsp_count), 32'd4);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy",      32'(busy),      32'd1);
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    wait_grant("bp_next");
    tick();
    req_valid = '0;

    // Withdrawn request: requester 1 pulses for one cycle while busy
    tick(); tick();
    check("wd_busy", 32'(busy), 32'd1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    drain("bp");
    repeat (6) tick();
    check("wd_idle", 32'(busy), 32'd0);

    // Reset at SHIFT cycle 4
    set_word(2, 8'hFF);
    grant_q.push_back(2);
    req_valid = 4'b0100;
    wait_grant("rst_job");
    tick();                             // cycle 1
    req_valid = '0;
    tick(); tick(); tick();             // cycle 4
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    tick();
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    set_word(0, 8'h55);
    set_word(2, 8'hFF);
    grant_q.push_back(0); push_job(0, 4);
    grant_q.push_back(2); push_job(2, 8);
    req_valid = 4'b0101;
    wait_grant("after_rst0");
    tick();
    req_valid = 4'b0100;
    wait_grant("after_rst2");
    tick();
    req_valid = '0;
    drain("after_rst");
`ifdef SEQ_DET_SCHED_STATS_EN
    tick();
    check("stat_jobs", 32'(stat_jobs), 32'd2);
    check("stat_hits", 32'(stat_hits), 32'd12);
`endif

    // Saturation on the CNT_W=2 instance
    begin
      bit seen;
      s_req_data[0 +: WORD_W] = 8'h12;
      s_req_valid = 4'b0001;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (s_req_ready != '0) seen = 1'b1;
      end
      check("sat_grant", 32'(s_req_ready), 32'd1);
      tick();
      s_req_valid = '0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (s_rsp_valid) seen = 1'b1;
      end
      check("sat_rsp_valid", 32'(s_rsp_valid), 32'd1);
      check("sat_rsp_id",    32'(s_rsp_id),    32'd0);
      check("sat_rsp_count", 32'(s_rsp_count), 32'd3);
`ifdef SEQ_DET_SCHED_STATS_EN
      check("sat_stat_hits_before", 32'(s_stat_hits), 32'd0);
      tick();
      check("sat_stat_hits", 32'(s_stat_hits), 32'd8);
      check("sat_stat_jobs", 32'(s_stat_jobs), 32'd1);
`endif
    end

    // Final report
    repeat (3) tick();
    check("exp_q_empty",   32'(exp_q.size()),   32'd0);
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
